mc_control_fsm: RTL and testbench



---
 rtl/mc_control_fsm.sv | 212 +++++++++++++++++++++
 tb/tb_mc_control_fsm.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_control_fsm.sv
// Multicycle MIPS control unit.
// Sequences fetch/decode/execute/memory/writeback and drives datapath controls.
module mc_control_fsm #(
  parameter int RA_REG = 31
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic [2:0] alu_cmd,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_src,
  output logic       pc_we,
  output logic       iord,
  output logic       mem_we,
  output logic       ir_we,
  output logic       reg_we,
  output logic [1:0] reg_dst,
  output logic [1:0] mem_to_reg,
  output logic       instr_done,
  output logic       illegal
);

  if (RA_REG < 0 || RA_REG > 31) begin : g_bad_ra
    $error("RA_REG must be a 5-bit register index");
  end

  typedef enum logic [4:0] {
    S_RESET, S_FETCH, S_DECODE, S_MEMADR, S_MEMRD,
    S_MEMWB, S_MEMWR, S_RTEX, S_RTWB, S_BEQ,
    S_BNE, S_JUMP, S_JAL, S_JR, S_ADDIEX,
    S_SLTIEX, S_IMMWB
  } state_t;

  localparam logic [5:0] OP_RT   = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_JAL  = 6'h03;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_SLTI = 6'h0A;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;

  localparam logic [5:0] F_JR  = 6'h08;
  localparam logic [5:0] F_ADD = 6'h20;
  localparam logic [5:0] F_SUB = 6'h22;
  localparam logic [5:0] F_AND = 6'h24;
  localparam logic [5:0] F_OR  = 6'h25;
  localparam logic [5:0] F_XOR = 6'h26;
  localparam logic [5:0] F_NOR = 6'h27;
  localparam logic [5:0] F_SLT = 6'h2A;

  localparam logic [2:0] A_ADD  = 3'b000;
  localparam logic [2:0] A_SUB  = 3'b001;
  localparam logic [2:0] A_XOR  = 3'b010;
  localparam logic [2:0] A_SLT  = 3'b011;
  localparam logic [2:0] A_AND  = 3'b100;
  localparam logic [2:0] A_NOR  = 3'b110;
  localparam logic [2:0] A_OR   = 3'b111;

  state_t state;
  state_t dec_next;
  logic   rt_ok;

  // Supported R-type ALU functions
  always_comb begin
    rt_ok = 1'b0;
    unique case (funct)
      F_ADD, F_SUB, F_XOR, F_SLT,
      F_AND, F_OR, F_NOR: rt_ok = 1'b1;
      default:            rt_ok = 1'b0;
    endcase
  end

  // Dispatch target out of DECODE; unsupported encodings refetch
  always_comb begin
    dec_next = S_FETCH;
    unique case (opcode)
      OP_RT: begin
        if (funct == F_JR) dec_next = S_JR;
        else if (rt_ok)    dec_next = S_RTEX;
        else               dec_next = S_FETCH;
      end
      OP_LW, OP_SW: dec_next = S_MEMADR;
      OP_BEQ:       dec_next = S_BEQ;
      OP_BNE:       dec_next = S_BNE;
      OP_J:         dec_next = S_JUMP;
      OP_JAL:       dec_next = S_JAL;
      OP_ADDI:      dec_next = S_ADDIEX;
      OP_SLTI:      dec_next = S_SLTIEX;
      default:      dec_next = S_FETCH;
    endcase
  end

  // State register; reset lands in RESET, stray codes recover to FETCH
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_RESET;
    end else begin
      unique case (state)
        S_RESET:  state <= S_FETCH;
        S_FETCH:  state <= S_DECODE;
        S_DECODE: state <= dec_next;
        S_MEMADR: state <= (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
        S_MEMRD:  state <= S_MEMWB;
        S_RTEX:   state <= S_RTWB;
        S_ADDIEX: state <= S_IMMWB;
        S_SLTIEX: state <= S_IMMWB;
        default:  state <= S_FETCH;
      endcase
    end
  end

  // Output decode: Moore from state, except RTEX alu_cmd, branch pc_we, illegal
  always_comb begin
    alu_cmd    = A_ADD;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    pc_src     = 2'b00;
    pc_we      = 1'b0;
    iord       = 1'b0;
    mem_we     = 1'b0;
    ir_we      = 1'b0;
    reg_we     = 1'b0;
    reg_dst    = 2'b00;
    mem_to_reg = 2'b00;
    instr_done = 1'b0;
    illegal    = 1'b0;
    unique case (state)
      S_FETCH: begin
        ir_we     = 1'b1;
        alu_src_b = 2'b01;
        pc_we     = 1'b1;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        illegal   = (dec_next == S_FETCH);
      end
      S_MEMADR, S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_SLTIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_cmd   = A_SLT;
      end
      S_MEMRD: iord = 1'b1;
      S_MEMWB: begin
        mem_to_reg = 2'b01;
        reg_we     = 1'b1;
        instr_done = 1'b1;
      end
      S_MEMWR: begin
        iord       = 1'b1;
        mem_we     = 1'b1;
        instr_done = 1'b1;
      end
      S_RTEX: begin
        alu_src_a = 1'b1;
        unique case (funct)
          F_SUB:   alu_cmd = A_SUB;
          F_XOR:   alu_cmd = A_XOR;
          F_SLT:   alu_cmd = A_SLT;
          F_AND:   alu_cmd = A_AND;
          F_OR:    alu_cmd = A_OR;
          F_NOR:   alu_cmd = A_NOR;
          default: alu_cmd = A_ADD;
        endcase
      end
      S_RTWB: begin
        reg_dst    = 2'b01;
        reg_we     = 1'b1;
        instr_done = 1'b1;
      end
      S_BEQ, S_BNE: begin
        alu_src_a  = 1'b1;
        alu_cmd    = A_SUB;
        pc_src     = 2'b01;
        pc_we      = (state == S_BEQ) ? zero : ~zero;
        instr_done = 1'b1;
      end
      S_JUMP: begin
        pc_src     = 2'b10;
        pc_we      = 1'b1;
        instr_done = 1'b1;
      end
      S_JAL: begin
        pc_src     = 2'b10;
        pc_we      = 1'b1;
        reg_we     = 1'b1;
        reg_dst    = 2'b10;
        mem_to_reg = 2'b10;
        instr_done = 1'b1;
      end
      S_JR: begin
        pc_src     = 2'b11;
        pc_we      = 1'b1;
        instr_done = 1'b1;
      end
      S_IMMWB: begin
        reg_we     = 1'b1;
        instr_done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Testbench for mc_control_fsm.
// Per-cycle outputs checked against an instruction-level model.
module tb_mc_control_fsm;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic [2:0] alu_cmd;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] pc_src;
  logic       pc_we, iord, mem_we, ir_we, reg_we;
  logic [1:0] reg_dst, mem_to_reg;
  logic       instr_done, illegal;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mc_control_fsm dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct),
    .zero(zero), .alu_cmd(alu_cmd), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .pc_src(pc_src), .pc_we(pc_we),
    .iord(iord), .mem_we(mem_we), .ir_we(ir_we), .reg_we(reg_we),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .instr_done(instr_done), .illegal(illegal)
  );

  typedef struct packed {
    logic [2:0] alu;
    logic       sa;
    logic [1:0] sb;
    logic [1:0] ps;
    logic       pw;
    logic       io;
    logic       mw;
    logic       iw;
    logic       rw;
    logic [1:0] rd;
    logic [1:0] mr;
    logic       dn;
    logic       il;
  } outs_t;

  typedef enum {K_LW, K_SW, K_RT, K_JR, K_BEQ, K_BNE,
                K_J, K_JAL, K_ADDI, K_SLTI, K_ILL} kind_t;

  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    logic       z;
    outs_t      last;
  } vec_t;

  function automatic outs_t o(
    input logic [2:0] alu, input logic sa, input logic [1:0] sb,
    input logic [1:0] ps, input logic pw, input logic io,
    input logic mw, input logic iw, input logic rw,
    input logic [1:0] rd, input logic [1:0] mr,
    input logic dn, input logic il);
    outs_t r;
    r = '{alu, sa, sb, ps, pw, io, mw, iw, rw, rd, mr, dn, il};
    return r;
  endfunction

  function automatic outs_t observe();
    return o(alu_cmd, alu_src_a, alu_src_b, pc_src, pc_we, iord,
             mem_we, ir_we, reg_we, reg_dst, mem_to_reg,
             instr_done, illegal);
  endfunction

  function automatic kind_t classify(input logic [5:0] op,
                                     input logic [5:0] fn);
    case (op)
      6'h00: begin
        if (fn == 6'h08) return K_JR;
        if (fn inside {6'h20, 6'h22, 6'h26, 6'h2A,
                       6'h24, 6'h25, 6'h27}) return K_RT;
        return K_ILL;
      end
      6'h23:   return K_LW;
      6'h2B:   return K_SW;
      6'h04:   return K_BEQ;
      6'h05:   return K_BNE;
      6'h02:   return K_J;
      6'h03:   return K_JAL;
      6'h08:   return K_ADDI;
      6'h0A:   return K_SLTI;
      default: return K_ILL;
    endcase
  endfunction

  function automatic int ilen(input kind_t k);
    case (k)
      K_LW:                      return 5;
      K_SW, K_RT, K_ADDI, K_SLTI: return 4;
      K_ILL:                     return 2;
      default:                   return 3;
    endcase
  endfunction

  function automatic logic [2:0] rt_alu(input logic [5:0] fn);
    case (fn)
      6'h22:   return 3'b001;
      6'h26:   return 3'b010;
      6'h2A:   return 3'b011;
      6'h24:   return 3'b100;
      6'h25:   return 3'b111;
      6'h27:   return 3'b110;
      default: return 3'b000;
    endcase
  endfunction

  // Expected outputs for step s (0 = fetch) of an instruction of kind k
  function automatic outs_t model(input kind_t k, input int s,
                                  input logic [5:0] fn, input logic z);
    outs_t r;
    r = '0;
    if (s == 0) begin
      r.iw = 1; r.sb = 2'b01; r.pw = 1;
      return r;
    end
    if (s == 1) begin
      r.sb = 2'b11; r.il = (k == K_ILL);
      return r;
    end
    case (k)
      K_LW, K_SW: begin
        if (s == 2) begin r.sa = 1; r.sb = 2'b10; end
        else if (s == 3) begin
          r.io = 1;
          if (k == K_SW) begin r.mw = 1; r.dn = 1; end
        end else begin
          r.rw = 1; r.mr = 2'b01; r.dn = 1;
        end
      end
      K_RT: begin
        if (s == 2) begin r.sa = 1; r.alu = rt_alu(fn); end
        else begin r.rd = 2'b01; r.rw = 1; r.dn = 1; end
      end
      K_ADDI, K_SLTI: begin
        if (s == 2) begin
          r.sa = 1; r.sb = 2'b10;
          r.alu = (k == K_SLTI) ? 3'b011 : 3'b000;
        end else begin r.rw = 1; r.dn = 1; end
      end
      K_BEQ, K_BNE: begin
        r.sa = 1; r.alu = 3'b001; r.ps = 2'b01; r.dn = 1;
        r.pw = (k == K_BEQ) ? z : !z;
      end
      K_J:   begin r.ps = 2'b10; r.pw = 1; r.dn = 1; end
      K_JAL: begin
        r.ps = 2'b10; r.pw = 1; r.rw = 1;
        r.rd = 2'b10; r.mr = 2'b10; r.dn = 1;
      end
      K_JR:  begin r.ps = 2'b11; r.pw = 1; r.dn = 1; end
      default: ;
    endcase
    return r;
  endfunction

  task automatic chk(input string name, input outs_t act,
                     input outs_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_excl(input string name);
    checks++;
    if ((mem_we && reg_we) || (ir_we && mem_we)) begin
      errors++;
      $display("FAIL %s exclusive enables: mem_we=%b reg_we=%b ir_we=%b",
               name, mem_we, reg_we, ir_we);
    end
  endtask

  // Runs one instruction from FETCH; zero is random per cycle when rz
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                           input logic z, input logic rz,
                           output outs_t last);
    kind_t k;
    int n;
    k = classify(op, fn);
    n = ilen(k);
    last = '0;
    for (int s = 0; s < n; s++) begin
      @(negedge clk);
      opcode = op;
      funct = fn;
      zero = rz ? 1'($urandom) : z;
      #1;
      last = observe();
      chk($sformatf("op%h fn%h step%0d", op, fn, s), last,
          model(k, s, fn, zero));
      chk_excl("cycle");
    end
  endtask

  task automatic do_reset_release();
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    #1 chk("reset state", observe(), '0);
  endtask

  vec_t vecs[$];
  outs_t last;
  logic [5:0] rops[12];
  logic [5:0] rfns[9];
  logic [5:0] op, fn;

  initial begin
    vecs.push_back('{6'h23, 6'h00, 1'b0,
      o(0,0,2'b00,2'b00,0,0,0,0,1,2'b00,2'b01,1,0)});
    vecs.push_back('{6'h2B, 6'h00, 1'b0,
      o(0,0,2'b00,2'b00,0,1,1,0,0,2'b00,2'b00,1,0)});
    vecs.push_back('{6'h00, 6'h22, 1'b0,
      o(0,0,2'b00,2'b00,0,0,0,0,1,2'b01,2'b00,1,0)});
    vecs.push_back('{6'h00, 6'h27, 1'b1,
      o(0,0,2'b00,2'b00,0,0,0,0,1,2'b01,2'b00,1,0)});
    vecs.push_back('{6'h00, 6'h2A, 1'b0,
      o(0,0,2'b00,2'b00,0,0,0,0,1,2'b01,2'b00,1,0)});
    vecs.push_back('{6'h04, 6'h00, 1'b1,
      o(3'b001,1,2'b00,2'b01,1,0,0,0,0,2'b00,2'b00,1,0)});
    vecs.push_back('{6'h04, 6'h00, 1'b0,
      o(3'b001,1,2'b00,2'b01,0,0,0,0,0,2'b00,2'b00,1,0)});
    vecs.push_back('{6'h05, 6'h00, 1'b1,
      o(3'b001,1,2'b00,2'b01,0,0,0,0,0,2'b00,2'b00,1,0)});
    vecs.push_back('{6'h05, 6'h00, 1'b0,
      o(3'b001,1,2'b00,2'b01,1,0,0,0,0,2'b00,2'b00,1,0)});
    vecs.push_back('{6'h02, 6'h00, 1'b0,
      o(0,0,2'b00,2'b10,1,0,0,0,0,2'b00,2'b00,1,0)});
    vecs.push_back('{6'h03, 6'h00, 1'b0,
      o(0,0,2'b00,2'b10,1,0,0,0,1,2'b10,2'b10,1,0)});
    vecs.push_back('{6'h00, 6'h08, 1'b0,
      o(0,0,2'b00,2'b11,1,0,0,0,0,2'b00,2'b00,1,0)});
    vecs.push_back('{6'h08, 6'h00, 1'b0,
      o(0,0,2'b00,2'b00,0,0,0,0,1,2'b00,2'b00,1,0)});
    vecs.push_back('{6'h0A, 6'h00, 1'b0,
      o(0,0,2'b00,2'b00,0,0,0,0,1,2'b00,2'b00,1,0)});
    vecs.push_back('{6'h3F, 6'h00, 1'b0,
      o(0,0,2'b11,2'b00,0,0,0,0,0,2'b00,2'b00,0,1)});
    vecs.push_back('{6'h00, 6'h00, 1'b0,
      o(0,0,2'b11,2'b00,0,0,0,0,0,2'b00,2'b00,0,1)});

    rops = '{6'h00, 6'h00, 6'h00, 6'h23, 6'h2B, 6'h04,
             6'h05, 6'h02, 6'h03, 6'h08, 6'h0A, 6'h3F};
    rfns = '{6'h20, 6'h22, 6'h26, 6'h2A, 6'h24,
             6'h25, 6'h27, 6'h08, 6'h00};

    rst_n = 1'b0;
    opcode = 6'h00;
    funct = 6'h20;
    zero = 1'b0;
    #1 chk("in reset", observe(), '0);
    repeat (2) @(posedge clk);
    do_reset_release();

    foreach (vecs[i]) begin
      run_instr(vecs[i].op, vecs[i].fn, vecs[i].z, 1'b0, last);
      chk($sformatf("vec%0d final", i), last, vecs[i].last);
    end

    for (int i = 0; i < 80; i++) begin
      op = rops[$urandom_range(0, 11)];
      if (op == 6'h3F) op = 6'($urandom);
      fn = rfns[$urandom_range(0, 8)];
      if ($urandom_range(0, 7) == 0) fn = 6'($urandom);
      run_instr(op, fn, 1'b0, 1'b1, last);
    end

    // Reset in the middle of a store's MEMWR cycle
    for (int s = 0; s < 4; s++) begin
      @(negedge clk);
      opcode = 6'h2B;
      funct = 6'h00;
      zero = 1'b0;
      #1;
      chk($sformatf("sw pre-reset step%0d", s), observe(),
          model(K_SW, s, 6'h00, 1'b0));
    end
    #1 rst_n = 1'b0;
    #1 chk("async reset mid-sw", observe(), '0);
    do_reset_release();
    run_instr(6'h23, 6'h00, 1'b0, 1'b0, last);
    chk("lw after reset", last,
        o(0,0,2'b00,2'b00,0,0,0,0,1,2'b00,2'b01,1,0));

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
